// File: rtl/bus_arbiter_if.sv
// Signal bundle between the CPU core, the DMA master and the external memory bus pins.
// The arbiter connects through the slave modport; the master modport drives the requesters.
interface bus_arbiter_if;
    logic        cpu_n_mreq;
    logic        cpu_n_iorq;
    logic        cpu_n_rd;
    logic        cpu_n_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_dout_en;
    logic        cpu_hold;
    logic        dma_req;
    logic        dma_gnt;
    logic        dma_n_mreq;
    logic        dma_n_rd;
    logic        dma_n_wr;
    logic [15:0] dma_addr;
    logic [7:0]  dma_dout;
    logic        bus_n_mreq;
    logic        bus_n_rd;
    logic        bus_n_wr;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_dout_en;

    modport slave (
        input  cpu_n_mreq, cpu_n_iorq, cpu_n_rd, cpu_n_wr, cpu_addr, cpu_dout, cpu_dout_en,
        input  dma_req, dma_n_mreq, dma_n_rd, dma_n_wr, dma_addr, dma_dout,
        output cpu_hold, dma_gnt,
        output bus_n_mreq, bus_n_rd, bus_n_wr, bus_addr, bus_dout, bus_dout_en
    );

    modport master (
        output cpu_n_mreq, cpu_n_iorq, cpu_n_rd, cpu_n_wr, cpu_addr, cpu_dout, cpu_dout_en,
        output dma_req, dma_n_mreq, dma_n_rd, dma_n_wr, dma_addr, dma_dout,
        input  cpu_hold, dma_gnt,
        input  bus_n_mreq, bus_n_rd, bus_n_wr, bus_addr, bus_dout, bus_dout_en
    );
endinterface

// File: rtl/bus_arbiter.sv
// Shares the external memory bus between the CPU and one DMA master, handing over only at
// idle bus boundaries with one turnaround cycle, bounded DMA tenure and a minimum CPU window.
//
// state    | meaning
// CPU      | CPU owns the bus, window counter running
// DRAIN    | DMA pending, CPU held, waiting for CPU bus cycle to end
// TURN_IN  | one idle bus cycle before DMA takes over
// DMA      | DMA granted, tenure counter running
// RELEASE  | grant withdrawn, waiting for DMA to finish its bus cycle
// TURN_OUT | one idle bus cycle before CPU takes over
module bus_arbiter #(
    parameter int MAX_DMA_CYCLES = 16,
    parameter int MIN_CPU_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bif
);
    typedef enum logic [2:0] {
        ST_CPU, ST_DRAIN, ST_TURN_IN, ST_DMA, ST_RELEASE, ST_TURN_OUT
    } state_t;

    localparam logic [7:0] TEN_LAST = 8'(MAX_DMA_CYCLES - 1);
    localparam logic [7:0] WIN_MIN  = 8'(MIN_CPU_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  ten_cnt_q, ten_cnt_d;
    logic [7:0]  win_cnt_q, win_cnt_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        dma_gnt_q, dma_gnt_d;
    logic        bus_n_mreq_q, bus_n_mreq_d;
    logic        bus_n_rd_q, bus_n_rd_d;
    logic        bus_n_wr_q, bus_n_wr_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic [7:0]  bus_dout_q, bus_dout_d;
    logic        bus_dout_en_q, bus_dout_en_d;
    logic        cpu_idle;
    logic        dma_idle;

    assign cpu_idle = bif.cpu_n_mreq & bif.cpu_n_iorq;
    assign dma_idle = bif.dma_n_mreq & bif.dma_n_rd & bif.dma_n_wr;

    always_comb begin
        state_d       = state_q;
        ten_cnt_d     = ten_cnt_q;
        win_cnt_d     = win_cnt_q;
        cpu_hold_d    = cpu_hold_q;
        dma_gnt_d     = dma_gnt_q;
        bus_n_mreq_d  = bus_n_mreq_q;
        bus_n_rd_d    = bus_n_rd_q;
        bus_n_wr_d    = bus_n_wr_q;
        bus_addr_d    = bus_addr_q;
        bus_dout_d    = bus_dout_q;
        bus_dout_en_d = bus_dout_en_q;

        unique case (state_q)
            ST_CPU: begin
                if (win_cnt_q != 8'hFF) win_cnt_d = win_cnt_q + 8'd1;
                if (bif.dma_req && (win_cnt_q >= WIN_MIN)) begin
                    state_d    = ST_DRAIN;
                    cpu_hold_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!bif.dma_req) begin
                    state_d    = ST_CPU;
                    cpu_hold_d = 1'b0;
                end else if (cpu_idle) begin
                    state_d = ST_TURN_IN;
                end
            end
            ST_TURN_IN: begin
                state_d   = ST_DMA;
                dma_gnt_d = 1'b1;
                ten_cnt_d = 8'd0;
            end
            ST_DMA: begin
                ten_cnt_d = ten_cnt_q + 8'd1;
                if (!bif.dma_req || (ten_cnt_q == TEN_LAST)) begin
                    state_d   = ST_RELEASE;
                    dma_gnt_d = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (dma_idle) state_d = ST_TURN_OUT;
            end
            ST_TURN_OUT: begin
                state_d    = ST_CPU;
                cpu_hold_d = 1'b0;
                win_cnt_d  = 8'd0;
            end
            default: begin
                state_d    = ST_CPU;
                cpu_hold_d = 1'b0;
                dma_gnt_d  = 1'b0;
            end
        endcase

        // Bus mux follows the owner of the current cycle; turnaround holds addr/dout.
        unique case (state_q)
            ST_CPU, ST_DRAIN: begin
                bus_n_mreq_d  = bif.cpu_n_mreq;
                bus_n_rd_d    = bif.cpu_n_rd;
                bus_n_wr_d    = bif.cpu_n_wr;
                bus_addr_d    = bif.cpu_addr;
                bus_dout_d    = bif.cpu_dout;
                bus_dout_en_d = bif.cpu_dout_en;
            end
            ST_DMA, ST_RELEASE: begin
                bus_n_mreq_d  = bif.dma_n_mreq;
                bus_n_rd_d    = bif.dma_n_rd;
                bus_n_wr_d    = bif.dma_n_wr;
                bus_addr_d    = bif.dma_addr;
                bus_dout_d    = bif.dma_dout;
                bus_dout_en_d = ~bif.dma_n_wr;
            end
            default: begin
                bus_n_mreq_d  = 1'b1;
                bus_n_rd_d    = 1'b1;
                bus_n_wr_d    = 1'b1;
                bus_dout_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_CPU;
            ten_cnt_q     <= 8'd0;
            win_cnt_q     <= WIN_MIN;
            cpu_hold_q    <= 1'b0;
            dma_gnt_q     <= 1'b0;
            bus_n_mreq_q  <= 1'b1;
            bus_n_rd_q    <= 1'b1;
            bus_n_wr_q    <= 1'b1;
            bus_addr_q    <= 16'h0000;
            bus_dout_q    <= 8'h00;
            bus_dout_en_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ten_cnt_q     <= ten_cnt_d;
            win_cnt_q     <= win_cnt_d;
            cpu_hold_q    <= cpu_hold_d;
            dma_gnt_q     <= dma_gnt_d;
            bus_n_mreq_q  <= bus_n_mreq_d;
            bus_n_rd_q    <= bus_n_rd_d;
            bus_n_wr_q    <= bus_n_wr_d;
            bus_addr_q    <= bus_addr_d;
            bus_dout_q    <= bus_dout_d;
            bus_dout_en_q <= bus_dout_en_d;
        end
    end

    assign bif.cpu_hold    = cpu_hold_q;
    assign bif.dma_gnt     = dma_gnt_q;
    assign bif.bus_n_mreq  = bus_n_mreq_q;
    assign bif.bus_n_rd    = bus_n_rd_q;
    assign bif.bus_n_wr    = bus_n_wr_q;
    assign bif.bus_addr    = bus_addr_q;
    assign bif.bus_dout    = bus_dout_q;
    assign bif.bus_dout_en = bus_dout_en_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: table-driven bus vectors through a scoreboard queue plus
// hand-written sequences for handover, drain, tenure cap, early release, abort and reset.
module tb_bus_arbiter;
    localparam int MAXC = 16;
    localparam int MINC = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_arbiter_if bif ();

    bus_arbiter #(.MAX_DMA_CYCLES(MAXC), .MIN_CPU_CYCLES(MINC)) dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bif)
    );

    typedef struct {
        logic        n_mreq, n_rd, n_wr;
        logic [15:0] addr;
        logic [7:0]  dout;
        logic        den;
    } bus_t;

    typedef struct {
        logic        n_mreq, n_iorq, n_rd, n_wr;
        logic [15:0] addr;
        logic [7:0]  dout;
        logic        den;
        bus_t        exp;
    } cpu_vec_t;

    typedef struct {
        logic        n_mreq, n_rd, n_wr;
        logic [15:0] addr;
        logic [7:0]  dout;
        bus_t        exp;
    } dma_vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    bus_t sb_q[$];
    cpu_vec_t cv[5];
    dma_vec_t dv[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input string name);
        bus_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got addr %0h expected an entry", name, bif.bus_addr);
        end else begin
            e = sb_q.pop_front();
            chk({name, ".n_mreq"}, 32'(bif.bus_n_mreq), 32'(e.n_mreq));
            chk({name, ".n_rd"},   32'(bif.bus_n_rd),   32'(e.n_rd));
            chk({name, ".n_wr"},   32'(bif.bus_n_wr),   32'(e.n_wr));
            chk({name, ".addr"},   32'(bif.bus_addr),   32'(e.addr));
            chk({name, ".dout"},   32'(bif.bus_dout),   32'(e.dout));
            chk({name, ".den"},    32'(bif.bus_dout_en), 32'(e.den));
        end
    endtask

    task automatic cpu_drive(input logic mreq, input logic rd, input logic [15:0] addr);
        bif.cpu_n_mreq = mreq;
        bif.cpu_n_iorq = 1'b1;
        bif.cpu_n_rd   = rd;
        bif.cpu_n_wr   = 1'b1;
        bif.cpu_addr   = addr;
        bif.cpu_dout_en = 1'b0;
    endtask

    task automatic dma_drive(input logic mreq, input logic rd, input logic wr,
                             input logic [15:0] addr, input logic [7:0] dout);
        bif.dma_n_mreq = mreq;
        bif.dma_n_rd   = rd;
        bif.dma_n_wr   = wr;
        bif.dma_addr   = addr;
        bif.dma_dout   = dout;
    endtask

    // Ownership invariant, checked every cycle outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            n_cmp++;
            if (bif.dma_gnt && !bif.cpu_hold) begin
                n_bad++;
                $display("FAIL owner_excl: got gnt=1 hold=0 expected never both owners");
            end
        end
    end

    initial begin
        int gnt_cycles;
        int hold_low;
        bit done;

        cv[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 8'h00, 1'b0, '{1'b0, 1'b0, 1'b1, 16'h1234, 8'h00, 1'b0}};
        cv[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'hABCD, 8'h5A, 1'b1, '{1'b0, 1'b1, 1'b0, 16'hABCD, 8'h5A, 1'b1}};
        cv[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h00FF, 8'hC3, 1'b1, '{1'b1, 1'b1, 1'b0, 16'h00FF, 8'hC3, 1'b1}};
        cv[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 8'h00, 1'b0, '{1'b1, 1'b1, 1'b1, 16'hFFFF, 8'h00, 1'b0}};
        cv[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 8'h81, 1'b0, '{1'b0, 1'b0, 1'b1, 16'h0001, 8'h81, 1'b0}};
        dv[0] = '{1'b0, 1'b0, 1'b1, 16'h8000, 8'h11, '{1'b0, 1'b0, 1'b1, 16'h8000, 8'h11, 1'b0}};
        dv[1] = '{1'b0, 1'b1, 1'b0, 16'h8001, 8'h22, '{1'b0, 1'b1, 1'b0, 16'h8001, 8'h22, 1'b1}};
        dv[2] = '{1'b1, 1'b1, 1'b1, 16'h8002, 8'h33, '{1'b1, 1'b1, 1'b1, 16'h8002, 8'h33, 1'b0}};
        dv[3] = '{1'b0, 1'b1, 1'b0, 16'hFFFE, 8'h44, '{1'b0, 1'b1, 1'b0, 16'hFFFE, 8'h44, 1'b1}};

        cpu_drive(1'b1, 1'b1, 16'h0000);
        bif.cpu_dout = 8'h00;
        bif.dma_req  = 1'b0;
        dma_drive(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);

        // Reset state
        reset = 1'b1;
        step();
        step();
        chk("rst.gnt", 32'(bif.dma_gnt), 0);
        chk("rst.hold", 32'(bif.cpu_hold), 0);
        chk("rst.strobes", 32'({bif.bus_n_mreq, bif.bus_n_rd, bif.bus_n_wr}), 32'h7);
        chk("rst.addr", 32'(bif.bus_addr), 0);
        chk("rst.dout", 32'(bif.bus_dout), 0);
        chk("rst.den", 32'(bif.bus_dout_en), 0);
        reset = 1'b0;

        // CPU pass-through vectors
        foreach (cv[i]) begin
            bif.cpu_n_mreq  = cv[i].n_mreq;
            bif.cpu_n_iorq  = cv[i].n_iorq;
            bif.cpu_n_rd    = cv[i].n_rd;
            bif.cpu_n_wr    = cv[i].n_wr;
            bif.cpu_addr    = cv[i].addr;
            bif.cpu_dout    = cv[i].dout;
            bif.cpu_dout_en = cv[i].den;
            sb_q.push_back(cv[i].exp);
            step();
            sb_check($sformatf("cpu_vec%0d", i));
            chk($sformatf("cpu_vec%0d.hold", i), 32'(bif.cpu_hold), 0);
        end

        // Idle handover
        cpu_drive(1'b1, 1'b1, 16'h0001);
        bif.dma_req = 1'b1;
        step();
        chk("ho1.hold", 32'(bif.cpu_hold), 1);
        chk("ho1.gnt", 32'(bif.dma_gnt), 0);
        step();
        chk("ho2.gnt", 32'(bif.dma_gnt), 0);
        chk("ho2.mreq", 32'(bif.bus_n_mreq), 1);
        step();
        chk("ho3.gnt", 32'(bif.dma_gnt), 1);
        chk("ho3.turn_strobes", 32'({bif.bus_n_mreq, bif.bus_n_rd, bif.bus_n_wr, bif.bus_dout_en}), 32'hE);
        gnt_cycles = 1;

        // DMA vectors, then tenure cap with dma_req held
        foreach (dv[i]) begin
            dma_drive(dv[i].n_mreq, dv[i].n_rd, dv[i].n_wr, dv[i].addr, dv[i].dout);
            sb_q.push_back(dv[i].exp);
            step();
            sb_check($sformatf("dma_vec%0d", i));
            if (bif.dma_gnt) gnt_cycles++;
        end
        dma_drive(1'b1, 1'b1, 1'b1, 16'h8003, 8'h00);
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            step();
            if (bif.dma_gnt) gnt_cycles++;
            else done = 1'b1;
        end
        chk("tenure.cycles", 32'(gnt_cycles), 32'(MAXC));
        chk("tenure.release_hold", 32'(bif.cpu_hold), 1);

        // CPU window between grants; CPU kept busy so the next request must drain
        cpu_drive(1'b0, 1'b0, 16'h1234);
        hold_low = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            step();
            if (!bif.cpu_hold) hold_low++;
            else if (hold_low > 0) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL window_timeout: got hold_low=%0d expected hold to re-assert", hold_low);
        end
        // Entry clears win_cnt and the grant needs win_cnt>=MIN, so CPU state lasts MIN+1 cycles.
        chk("window.cycles", 32'(hold_low), 32'(MINC + 1));

        // Drain: CPU still busy, no grant
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("drain%0d.gnt", k), 32'(bif.dma_gnt), 0);
            chk($sformatf("drain%0d.cpu_mreq", k), 32'(bif.bus_n_mreq), 0);
        end
        cpu_drive(1'b1, 1'b1, 16'h1234);
        step();
        chk("drain_turn.gnt", 32'(bif.dma_gnt), 0);
        chk("drain_turn.mreq", 32'(bif.bus_n_mreq), 1);
        step();
        chk("drain_gnt", 32'(bif.dma_gnt), 1);
        chk("drain_gnt.mreq", 32'(bif.bus_n_mreq), 1);

        // Early release with a write still in progress
        dma_drive(1'b0, 1'b1, 1'b0, 16'h9000, 8'hA5);
        step();
        step();
        bif.dma_req = 1'b0;
        step();
        chk("rel1.gnt", 32'(bif.dma_gnt), 0);
        chk("rel1.hold", 32'(bif.cpu_hold), 1);
        chk("rel1.den", 32'(bif.bus_dout_en), 1);
        step();
        chk("rel2.hold", 32'(bif.cpu_hold), 1);
        chk("rel2.n_wr", 32'(bif.bus_n_wr), 0);
        dma_drive(1'b1, 1'b1, 1'b1, 16'h9000, 8'hA5);
        step();
        chk("tout.hold", 32'(bif.cpu_hold), 1);
        chk("tout.den", 32'(bif.bus_dout_en), 0);
        step();
        chk("rel_cpu.hold", 32'(bif.cpu_hold), 0);
        chk("rel_cpu.den", 32'(bif.bus_dout_en), 0);
        chk("rel_cpu.strobes", 32'({bif.bus_n_mreq, bif.bus_n_rd, bif.bus_n_wr}), 32'h7);
        chk("rel_cpu.addr_hold", 32'(bif.bus_addr), 32'h9000);
        chk("rel_cpu.dout_hold", 32'(bif.bus_dout), 32'hA5);

        // Abort in DRAIN: one-cycle request while the CPU is busy
        cpu_drive(1'b0, 1'b0, 16'h2222);
        for (int k = 0; k < 6; k++) step();
        bif.dma_req = 1'b1;
        step();
        chk("abort.hold1", 32'(bif.cpu_hold), 1);
        bif.dma_req = 1'b0;
        step();
        chk("abort.hold0", 32'(bif.cpu_hold), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("abort%0d.gnt", k), 32'(bif.dma_gnt), 0);
        end

        // Reset in the middle of a DMA tenure
        cpu_drive(1'b1, 1'b1, 16'h2222);
        bif.dma_req = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            step();
            if (bif.dma_gnt) done = 1'b1;
        end
        chk("rst_dma.granted", 32'(bif.dma_gnt), 1);
        dma_drive(1'b0, 1'b0, 1'b1, 16'h4321, 8'h00);
        step();
        chk("rst_dma.addr", 32'(bif.bus_addr), 32'h4321);
        reset = 1'b1;
        step();
        chk("rst_dma1.gnt", 32'(bif.dma_gnt), 0);
        chk("rst_dma1.hold", 32'(bif.cpu_hold), 0);
        chk("rst_dma1.strobes", 32'({bif.bus_n_mreq, bif.bus_n_rd, bif.bus_n_wr}), 32'h7);
        chk("rst_dma1.addr", 32'(bif.bus_addr), 0);
        step();
        chk("rst_dma2.gnt", 32'(bif.dma_gnt), 0);
        reset = 1'b0;
        step();
        chk("post_rst.hold", 32'(bif.cpu_hold), 1);
        bif.dma_req = 1'b0;
        step();
        chk("post_rst.drop", 32'(bif.cpu_hold), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
